// File: rtl/serial_work_link.sv
// serial_work_link: framed serial work receiver and nonce transmitter.
//   Received bytes are framed into WORK_BYTES-long work units (first byte in
//   the MSBs). A partial frame is dropped after RX_TIMEOUT idle cycles.
//   Nonces are queued in a small FIFO and sent as four bytes, MSB first.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   rx / tx             - serial pins (8N1)
//   work, work_valid    - last complete frame, one-cycle update pulse
//   rx_frame_error      - pulse when a partial frame is discarded on timeout
//   rx_busy             - a partial frame is being held
//   nonce, nonce_valid  - result word push interface
//   nonce_full, tx_overflow, fifo_level - FIFO status / dropped-push pulse
//   tx_busy             - transmitter active or FIFO non-empty
// The file also carries the uart byte core it is built on.

// uart: 8N1 byte transceiver. rx is sampled SAMPLE_POINT/16 into each bit.
// A byte already on the wire completes even if rst arrives mid-byte.
module uart #(
    parameter int CLOCK        = 25000000,
    parameter int BAUD         = 57600,
    parameter int SAMPLE_POINT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       tx_start,
    input  logic [7:0] tx_byte,
    output logic       tx,
    output logic       tx_busy,
    output logic       rx_data_ready,
    output logic [7:0] rx_data
);
    localparam int DIV  = CLOCK / BAUD;
    localparam int SAMP = DIV * SAMPLE_POINT / 16;
    localparam int CW   = $clog2(DIV + 1);

    logic [1:0]    r_rx_sync;
    logic          r_rx_active;
    logic [CW-1:0] r_rx_cnt;
    logic [3:0]    r_rx_bit;
    logic [7:0]    r_rx_data;
    logic          r_rx_ready;

    always_ff @(posedge clk) begin
        r_rx_sync  <= {r_rx_sync[0], rx};
        r_rx_ready <= 1'b0;
        if (rst) begin
            r_rx_sync   <= 2'b11;
            r_rx_active <= 1'b0;
            r_rx_cnt    <= '0;
            r_rx_bit    <= '0;
            r_rx_data   <= '0;
        end else if (!r_rx_active) begin
            if (!r_rx_sync[1]) begin
                r_rx_active <= 1'b1;
                r_rx_cnt    <= CW'(1);
                r_rx_bit    <= '0;
            end
        end else begin
            if (r_rx_cnt == CW'(DIV - 1)) begin
                r_rx_cnt <= '0;
                r_rx_bit <= r_rx_bit + 4'd1;
            end else begin
                r_rx_cnt <= r_rx_cnt + CW'(1);
            end
            if (r_rx_cnt == CW'(SAMP)) begin
                if (r_rx_bit == 4'd0) begin
                    // Start bit gone high again: treat as a glitch.
                    if (r_rx_sync[1]) r_rx_active <= 1'b0;
                end else if (r_rx_bit == 4'd9) begin
                    // Returning to idle mid stop bit lets a back-to-back
                    // start edge be caught; a bad stop bit drops the byte.
                    r_rx_active <= 1'b0;
                    r_rx_ready  <= r_rx_sync[1];
                end else begin
                    r_rx_data <= {r_rx_sync[1], r_rx_data[7:1]};
                end
            end
        end
    end

    assign rx_data_ready = r_rx_ready;
    assign rx_data       = r_rx_data;

    logic [9:0]    r_tx_sh;
    logic [CW-1:0] r_tx_cnt;
    logic [3:0]    r_tx_bit;
    logic          r_tx_busy;

    // Reset only takes effect between bytes so a started frame is never cut.
    always_ff @(posedge clk) begin
        if (r_tx_busy) begin
            if (r_tx_cnt >= CW'(DIV - 1)) begin
                r_tx_cnt <= '0;
                r_tx_sh  <= {1'b1, r_tx_sh[9:1]};
                r_tx_bit <= r_tx_bit + 4'd1;
                if (r_tx_bit >= 4'd9) r_tx_busy <= 1'b0;
            end else begin
                r_tx_cnt <= r_tx_cnt + CW'(1);
            end
        end else if (rst) begin
            r_tx_sh  <= '1;
            r_tx_cnt <= '0;
            r_tx_bit <= '0;
        end else if (tx_start) begin
            r_tx_sh   <= {1'b1, tx_byte, 1'b0};
            r_tx_cnt  <= '0;
            r_tx_bit  <= '0;
            r_tx_busy <= 1'b1;
        end
    end

    assign tx      = r_tx_sh[0];
    assign tx_busy = r_tx_busy;
endmodule

module serial_work_link #(
    parameter int CLOCK        = 25000000,
    parameter int BAUD         = 57600,
    parameter int SAMPLE_POINT = 8,
    parameter int WORK_BYTES   = 64,
    parameter int FIFO_DEPTH   = 4,
    parameter int RX_TIMEOUT   = 2500000
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            rx,
    output logic                            tx,
    output logic [WORK_BYTES*8-1:0]         work,
    output logic                            work_valid,
    output logic                            rx_frame_error,
    output logic                            rx_busy,
    input  logic [31:0]                     nonce,
    input  logic                            nonce_valid,
    output logic                            nonce_full,
    output logic                            tx_overflow,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic                            tx_busy
);
    localparam int WW  = WORK_BYTES * 8;
    localparam int ICW = (RX_TIMEOUT > 1) ? $clog2(RX_TIMEOUT) : 1;
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int LW  = PW + 1;

    logic       w_rx_ready;
    logic [7:0] w_rx_data;
    logic       w_uart_busy;
    logic       r_tx_start;
    logic [7:0] r_tx_byte;

    uart #(.CLOCK(CLOCK), .BAUD(BAUD), .SAMPLE_POINT(SAMPLE_POINT)) u_uart (
        .clk           (clk),
        .rst           (rst),
        .rx            (rx),
        .tx_start      (r_tx_start),
        .tx_byte       (r_tx_byte),
        .tx            (tx),
        .tx_busy       (w_uart_busy),
        .rx_data_ready (w_rx_ready),
        .rx_data       (w_rx_data)
    );

    // ---------------- RX framing and inter-byte timeout ----------------
    logic [WW-1:0]  r_shift;
    logic [WW-1:0]  r_work;
    logic [7:0]     r_byte_cnt;
    logic [ICW-1:0] r_idle_cnt;
    logic           r_work_valid;
    logic           r_rx_frame_error;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift          <= '0;
            r_work           <= '0;
            r_byte_cnt       <= '0;
            r_idle_cnt       <= '0;
            r_work_valid     <= 1'b0;
            r_rx_frame_error <= 1'b0;
        end else begin
            r_work_valid     <= 1'b0;
            r_rx_frame_error <= 1'b0;
            // An arriving byte takes priority over a timeout in the same cycle.
            if (w_rx_ready) begin
                r_shift    <= {r_shift[WW-9:0], w_rx_data};
                r_idle_cnt <= '0;
                if (r_byte_cnt == 8'(WORK_BYTES - 1)) begin
                    r_work       <= {r_shift[WW-9:0], w_rx_data};
                    r_work_valid <= 1'b1;
                    r_byte_cnt   <= '0;
                end else begin
                    r_byte_cnt <= r_byte_cnt + 8'd1;
                end
            end else if (r_byte_cnt != 8'd0) begin
                if (r_idle_cnt == ICW'(RX_TIMEOUT - 1)) begin
                    r_byte_cnt       <= '0;
                    r_idle_cnt       <= '0;
                    r_rx_frame_error <= 1'b1;
                end else begin
                    r_idle_cnt <= r_idle_cnt + ICW'(1);
                end
            end
        end
    end

    assign work           = r_work;
    assign work_valid     = r_work_valid;
    assign rx_frame_error = r_rx_frame_error;
    assign rx_busy        = (r_byte_cnt != 8'd0);

    // ---------------- Nonce FIFO and TX sequencer ----------------
    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT_BUSY, S_WAIT_DONE} tx_state_t;

    logic [31:0]   r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wr;
    logic [PW-1:0] r_rd;
    logic [LW-1:0] r_level;
    logic          r_tx_overflow;
    tx_state_t     r_state;
    logic [31:0]   r_tx_word;
    logic [1:0]    r_byte_idx;
    logic          w_push;
    logic          w_pop;

    // Acceptance uses the start-of-cycle level; a same-cycle pop does not help.
    assign w_push = nonce_valid && (r_level < LW'(FIFO_DEPTH));
    assign w_pop  = (r_state == S_IDLE) && (r_level != '0);

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= nonce;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr          <= '0;
            r_rd          <= '0;
            r_level       <= '0;
            r_tx_overflow <= 1'b0;
            r_state       <= S_IDLE;
            r_tx_word     <= '0;
            r_byte_idx    <= '0;
            r_tx_start    <= 1'b0;
            r_tx_byte     <= '0;
        end else begin
            r_tx_overflow <= nonce_valid && !w_push;
            if (w_push) r_wr <= r_wr + PW'(1);
            if (w_pop)  r_rd <= r_rd + PW'(1);
            r_level    <= r_level + LW'(w_push) - LW'(w_pop);
            r_tx_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_tx_word  <= r_mem[r_rd];
                        r_byte_idx <= '0;
                        r_state    <= S_START;
                    end
                end
                S_START: begin
                    if (!w_uart_busy) begin
                        r_tx_byte  <= r_tx_word[31:24];
                        r_tx_start <= 1'b1;
                        r_state    <= S_WAIT_BUSY;
                    end
                end
                S_WAIT_BUSY: begin
                    if (w_uart_busy) r_state <= S_WAIT_DONE;
                end
                default: begin
                    if (!w_uart_busy) begin
                        if (r_byte_idx == 2'd3) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_tx_word  <= {r_tx_word[23:0], 8'h00};
                            r_byte_idx <= r_byte_idx + 2'd1;
                            r_state    <= S_START;
                        end
                    end
                end
            endcase
        end
    end

    assign nonce_full  = (r_level == LW'(FIFO_DEPTH));
    assign tx_overflow = r_tx_overflow;
    assign fifo_level  = r_level;
    assign tx_busy     = (r_state != S_IDLE) || (r_level != '0);
endmodule

// File: doc/serial_work_link.md
# serial_work_link

Parametrised serial work/result link for the Cairnsmore1 miner bitstream. It succeeds the fixed 64-byte/single-word serial core. It instantiates the existing `uart` byte core and frames received bytes into a work unit of configurable length, with an inter-byte timeout that resynchronises partial frames. Nonces go through a configurable FIFO and are sent MSB first. It sits between the board UART pins and the hashing cores.

## Interface
- `CLOCK`, 25000000: clk frequency in Hz; passed to `uart`.
- `BAUD`, 57600: line rate; passed to `uart`.
- `SAMPLE_POINT`, 8: RX sample point; passed to `uart`.
- `WORK_BYTES`, 64: bytes per work frame; range 2..255.
- `FIFO_DEPTH`, 4: nonce FIFO entries; power of 2, range 2..16.
- `RX_TIMEOUT`, 2500000: idle clk cycles after which a partial frame is discarded; must be ≥ 1.
- `clk` in 1: single clock; everything is synchronous to its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `rx` in 1: serial input pin.
- `tx` out 1: serial output pin.
- `work` out WORK_BYTES*8: last complete frame. First byte received sits in the MSBs (bits [WORK_BYTES*8-1 -: 8]).
- `work_valid` out 1: one-cycle pulse when `work` updates.
- `rx_frame_error` out 1: one-cycle pulse when a partial frame is discarded on timeout.
- `rx_busy` out 1: high while a partial frame is held (byte count ≠ 0).
- `nonce` in 32: result word to send.
- `nonce_valid` in 1: push request, sampled every cycle.
- `nonce_full` out 1: FIFO level == FIFO_DEPTH.
- `tx_overflow` out 1: one-cycle pulse when a push is dropped.
- `fifo_level` out $clog2(FIFO_DEPTH)+1: current FIFO occupancy.
- `tx_busy` out 1: high when the TX FSM is not IDLE or the FIFO is non-empty.

## Operation
- RX framing:
  - Each `uart` rx_data_ready pulse shifts the byte into an internal WORK_BYTES*8 shift register (shift left by 8, new byte in [7:0]) and increments byte_cnt.
  - On the byte that makes byte_cnt == WORK_BYTES: the full shift register is copied to `work`, `work_valid` pulses, and byte_cnt returns to 0.
  - `work` holds its value between frames. A partial frame never alters `work`.
- RX timeout:
  - idle_cnt clears on every received byte.
  - While byte_cnt ≠ 0 and no byte arrives, idle_cnt increments.
  - When idle_cnt reaches RX_TIMEOUT-1: byte_cnt clears to 0, `rx_frame_error` pulses and idle_cnt clears.
  - A byte arriving in that same cycle wins: the byte is accepted, there is no error, and idle_cnt clears.
- Nonce FIFO:
  - A push is accepted iff `nonce_valid` is high and the level at the start of the cycle is < FIFO_DEPTH.
  - Otherwise the word is dropped and `tx_overflow` pulses. A pop in the same cycle does not rescue the push.
  - Simultaneous accepted push and pop leave the level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- TX FSM states:
  - IDLE: if FIFO non-empty, pop the head into tx_word, set byte_idx=0, go to START.
  - START: when `uart` tx_busy==0, drive tx_byte=tx_word[31:24], assert tx_start for exactly one cycle, go to WAIT_BUSY.
  - WAIT_BUSY: wait for uart tx_busy==1, then go to WAIT_DONE.
  - WAIT_DONE: wait for uart tx_busy==0. Then:
    - if byte_idx==3, go to IDLE;
    - else shift tx_word left 8, increment byte_idx, go to START.
- Byte order on the wire: nonce[31:24], [23:16], [15:8], [7:0].

## Timing
- Reset values:
  - `work`=0, `work_valid`=0, `rx_frame_error`=0, `rx_busy`=0.
  - `nonce_full`=0, `tx_overflow`=0, `fifo_level`=0, `tx_busy`=0.
  - FSM=IDLE, tx_start=0, byte_cnt=0, idle_cnt=0, FIFO pointers=0.
- Reset mid-operation:
  - Discards the partial frame and all FIFO contents.
  - A byte already started inside `uart` finishes on the pin; no further bytes start.
- `work`/`work_valid` latency: both change on the cycle after the final rx_data_ready.
- `fifo_level`/`nonce_full` reflect a push or pop one cycle after the request.
- Pop latency: IDLE pops in the cycle after the level becomes non-zero; tx_start follows one cycle later if the UART is idle.
- Per-word wire time: 4 UART byte frames plus ≤ 4 clk of FSM overhead per byte.
- `tx_busy` drops to 0 on the cycle after the fourth byte's WAIT_DONE exit, provided the FIFO is empty.

## Test plan
- Full frame (bench RX_TIMEOUT=20000): send 64 bytes 0x00..0x3F at 57600 baud.
  - Exactly one `work_valid` pulse.
  - `work[511:504]`=0x00, `work[7:0]`=0x3F.
  - `rx_busy` is low afterwards.
- Timeout resync: send 10 bytes, idle 25000 cycles, then 64 bytes of 0xA5.
  - One `rx_frame_error` pulse, then one `work_valid` pulse.
  - `work` equals all 0xA5; the first 10 bytes are absent.
- Single nonce: push 0xDEADBEEF.
  - Wire shows 0xDE, 0xAD, 0xBE, 0xEF in order.
  - `tx_busy` is high from the push until the last stop bit, then low.
- FIFO full (FIFO_DEPTH=4): push 6 words 0x1..0x6 on consecutive cycles while TX idles.
  - The sixth is dropped (`tx_overflow` pulse).
  - The fifth is accepted or dropped strictly per the start-of-cycle level rule.
  - The wire carries the accepted words in order.
- Timeout/byte collision: align a byte arrival with idle_cnt==RX_TIMEOUT-1.
  - No `rx_frame_error`.
  - byte_cnt increments.
- Reset mid-activity: assert `rst` for 1 cycle after 30 RX bytes with 3 nonces queued.
  - All outputs return to reset values.
  - The next 64 bytes form a clean frame.
  - No queued nonce is transmitted.
